updown_pattern_counter: RTL and testbench

Parametrised successor to the team's 4-bit bounce counter. Generates up-wrap, down-wrap, bounce-with-endpoint-repeat and bounce-without-repeat count sequences. Min/Max bounds, step size and start value are set at run time. Used as a pattern/address generator for test stimulus and display sweeps; outputs are fully registered.

---
 rtl/updown_pattern_counter.sv | 131 +++++++++++++
 tb/tb_updown_pattern_counter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/updown_pattern_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_pattern_counter
// Purpose  : Run-time bounded up/down/bounce count-pattern generator.
//            Count, direction and terminal-count outputs are all registered.
// Revision : 1.0 - initial release
// ============================================================================
module updown_pattern_counter #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] Min,
    input  logic [WIDTH-1:0] Max,
    input  logic [WIDTH-1:0] Step,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] Out,
    output logic             Dir,
    output logic             Tc
);

    localparam logic [1:0] MODE_UP_WRAP     = 2'd0;
    localparam logic [1:0] MODE_DOWN_WRAP   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE_HOLD = 2'd2;
    localparam logic [1:0] MODE_BOUNCE      = 2'd3;

    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             tc_q,  tc_d;
    logic [WIDTH-1:0] step_eff;

    // One extra bit catches carry/borrow so results saturate instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_up(input logic [WIDTH-1:0] base,
                                                input logic [WIDTH-1:0] st,
                                                input logic [WIDTH-1:0] hi);
        logic [WIDTH:0] s;
        s = {1'b0, base} + {1'b0, st};
        return (s > {1'b0, hi}) ? hi : s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_dn(input logic [WIDTH-1:0] base,
                                                input logic [WIDTH-1:0] st,
                                                input logic [WIDTH-1:0] lo);
        logic [WIDTH:0] d;
        d = {1'b0, base} - {1'b0, st};
        return (d[WIDTH] || (d[WIDTH-1:0] < lo)) ? lo : d[WIDTH-1:0];
    endfunction

    assign step_eff = (Step == '0) ? WIDTH'(1) : Step;

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        if (Load) begin
            if (LoadValue < Min)      out_d = Min;
            else if (LoadValue > Max) out_d = Max;
            else                      out_d = LoadValue;
            dir_d = (Mode == MODE_DOWN_WRAP);
        end else if (Enable) begin
            if (Max <= Min) begin
                out_d = Min;
            end else if (out_q < Min) begin
                out_d = Min;
            end else if (out_q > Max) begin
                out_d = Max;
            end else begin
                case (Mode)
                    MODE_UP_WRAP: begin
                        dir_d = 1'b0;
                        if (out_q == Max) begin
                            out_d = Min;
                            tc_d  = 1'b1;
                        end else begin
                            out_d = sat_up(out_q, step_eff, Max);
                        end
                    end
                    MODE_DOWN_WRAP: begin
                        dir_d = 1'b1;
                        if (out_q == Min) begin
                            out_d = Max;
                            tc_d  = 1'b1;
                        end else begin
                            out_d = sat_dn(out_q, step_eff, Min);
                        end
                    end
                    MODE_BOUNCE_HOLD, MODE_BOUNCE: begin
                        // Endpoint reversal: HOLD repeats the endpoint, BOUNCE steps away at once.
                        if (!dir_q && out_q == Max) begin
                            dir_d = 1'b1;
                            tc_d  = 1'b1;
                            if (Mode == MODE_BOUNCE) out_d = sat_dn(Max, step_eff, Min);
                        end else if (dir_q && out_q == Min) begin
                            dir_d = 1'b0;
                            tc_d  = 1'b1;
                            if (Mode == MODE_BOUNCE) out_d = sat_up(Min, step_eff, Max);
                        end else if (!dir_q) begin
                            out_d = sat_up(out_q, step_eff, Max);
                        end else begin
                            out_d = sat_dn(out_q, step_eff, Min);
                        end
                    end
                    default: begin
                        out_d = out_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_q <= '0;
            dir_q <= 1'b0;
            tc_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
        end
    end

    assign Out = out_q;
    assign Dir = dir_q;
    assign Tc  = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_pattern_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_pattern_counter
// Purpose  : Directed self-checking bench for updown_pattern_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_pattern_counter;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b0;
    logic [1:0] Mode = 2'd0;
    logic [3:0] Min = 4'd0;
    logic [3:0] Max = 4'd15;
    logic [3:0] Step = 4'd1;
    logic       Load = 1'b0;
    logic [3:0] LoadValue = 4'd0;
    logic [3:0] Out;
    logic       Dir;
    logic       Tc;

    int compared = 0;
    int mismatched = 0;
    int tc_count = 0;

    updown_pattern_counter #(.WIDTH(4)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode),
        .Min(Min), .Max(Max), .Step(Step), .Load(Load), .LoadValue(LoadValue),
        .Out(Out), .Dir(Dir), .Tc(Tc)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_out,
                       input logic e_dir, input logic e_tc);
        compared++;
        assert ({Out, Dir, Tc} === {e_out, e_dir, e_tc}) else begin
            mismatched++;
            $error("FAIL %s: Out/Dir/Tc observed %0d/%0b/%0b expected %0d/%0b/%0b",
                   tag, Out, Dir, Tc, e_out, e_dir, e_tc);
        end
        if (Tc === 1'b1) tc_count++;
    endtask

    initial begin
        // Reset state
        Reset = 1'b1; tick(); chk("reset", 4'd0, 1'b0, 1'b0);

        // Bounce-with-hold over full range
        Reset = 1'b0; Mode = 2'd2; Min = 4'd0; Max = 4'd15; Step = 4'd1; Enable = 1'b1;
        tc_count = 0;
        for (int i = 1; i <= 15; i++) begin tick(); chk("hold_up", 4'(i), 1'b0, 1'b0); end
        tick(); chk("hold_top", 4'd15, 1'b1, 1'b1);
        for (int i = 14; i >= 0; i--) begin tick(); chk("hold_dn", 4'(i), 1'b1, 1'b0); end
        tick(); chk("hold_bot", 4'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) begin tick(); chk("hold_up2", 4'(i), 1'b0, 1'b0); end
        compared++;
        assert (tc_count == 2) else begin
            mismatched++;
            $error("FAIL hold_tc_count: observed %0d expected 2", tc_count);
        end

        // Bounce without repeat, 3..9 step 2
        Mode = 2'd3; Min = 4'd3; Max = 4'd9; Step = 4'd2; Load = 1'b1; LoadValue = 4'd3;
        tick(); chk("b_load", 4'd3, 1'b0, 1'b0);
        Load = 1'b0;
        tick(); chk("b_5", 4'd5, 1'b0, 1'b0);
        tick(); chk("b_7", 4'd7, 1'b0, 1'b0);
        tick(); chk("b_9", 4'd9, 1'b0, 1'b0);
        tick(); chk("b_rev7", 4'd7, 1'b1, 1'b1);
        tick(); chk("b_5d", 4'd5, 1'b1, 1'b0);
        tick(); chk("b_3d", 4'd3, 1'b1, 1'b0);
        tick(); chk("b_rev5", 4'd5, 1'b0, 1'b1);

        // Up-wrap 2..12 step 4, then down-wrap
        Mode = 2'd0; Min = 4'd2; Max = 4'd12; Step = 4'd4; Load = 1'b1; LoadValue = 4'd2;
        tick(); chk("u_load", 4'd2, 1'b0, 1'b0);
        Load = 1'b0;
        tick(); chk("u_6", 4'd6, 1'b0, 1'b0);
        tick(); chk("u_10", 4'd10, 1'b0, 1'b0);
        tick(); chk("u_sat12", 4'd12, 1'b0, 1'b0);
        tick(); chk("u_wrap2", 4'd2, 1'b0, 1'b1);
        tick(); chk("u_6b", 4'd6, 1'b0, 1'b0);
        Mode = 2'd1;
        tick(); chk("d_2", 4'd2, 1'b1, 1'b0);
        tick(); chk("d_wrap12", 4'd12, 1'b1, 1'b1);

        // Disable right after a Tc pulse, then load with clamp, then reset
        Enable = 1'b0;
        tick(); chk("dis_1", 4'd12, 1'b1, 1'b0);
        tick(); chk("dis_2", 4'd12, 1'b1, 1'b0);
        tick(); chk("dis_3", 4'd12, 1'b1, 1'b0);
        Load = 1'b1; LoadValue = 4'd14; Max = 4'd10;
        tick(); chk("load_clamp_hi", 4'd10, 1'b1, 1'b0);
        Load = 1'b0; Enable = 1'b1; Reset = 1'b1;
        tick(); chk("mid_reset", 4'd0, 1'b0, 1'b0);

        // Out-of-range correction, degenerate bounds, Step=0
        Reset = 1'b0; Mode = 2'd0; Min = 4'd0; Max = 4'd15; Step = 4'd1;
        Load = 1'b1; LoadValue = 4'd8;
        tick(); chk("load8", 4'd8, 1'b0, 1'b0);
        Load = 1'b0; Max = 4'd5;
        tick(); chk("corr_hi", 4'd5, 1'b0, 1'b0);
        Min = 4'd5;
        tick(); chk("degen", 4'd5, 1'b0, 1'b0);
        tick(); chk("degen2", 4'd5, 1'b0, 1'b0);
        Max = 4'd15; Step = 4'd0;
        tick(); chk("step0_6", 4'd6, 1'b0, 1'b0);
        tick(); chk("step0_7", 4'd7, 1'b0, 1'b0);
        Mode = 2'd1; Step = 4'd4;
        tick(); chk("dn_sat5", 4'd5, 1'b1, 1'b0);
        tick(); chk("dn_wrap15", 4'd15, 1'b1, 1'b1);
        Min = 4'd9; Enable = 1'b0; Load = 1'b1; LoadValue = 4'd1; Mode = 2'd2;
        tick(); chk("load_clamp_lo", 4'd9, 1'b0, 1'b0);
        Load = 1'b0; Enable = 1'b1; Min = 4'd12;
        tick(); chk("corr_lo", 4'd12, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
